// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES pad reader and its downstream consumers:
// FSM state codes, button bit positions and default timing.
package nes_pad_reader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_BIT0   = 3'd2;
  localparam logic [2:0] ST_CLK_HI = 3'd3;
  localparam logic [2:0] ST_CLK_LO = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Bit positions in buttons/presses, matching the controller's shift order.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int DEF_HALF_CYCLES = 600;
  localparam int DEF_POLL_CYCLES = 1666666;
  localparam int DEF_CNT_WIDTH   = 21;

endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs,
// with a parameterised value loaded during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES (CD4021) controller at a fixed rate, deserialises the eight
// button bits and publishes active-high state, press pulses and a valid strobe.
module nes_pad_reader
  import nes_pad_reader_pkg::*;
#(
  parameter int HALF_CYCLES = DEF_HALF_CYCLES,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic [7:0] presses,
  output logic       valid
);

  localparam logic [CNT_WIDTH-1:0] HALF_LAST  = CNT_WIDTH'(HALF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LATCH_LAST = CNT_WIDTH'(2 * HALF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] POLL_LAST  = CNT_WIDTH'(POLL_CYCLES - 1);

  logic                 rst_sync;
  logic                 synced_data;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] phase_cnt;
  logic [CNT_WIDTH-1:0] poll_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 frame_start;
  logic                 half_done;

  // Reset asserts asynchronously but is released on a clock edge.
  sync_2ff #(.RESET_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .reset (reset),
    .d     (1'b1),
    .q     (rst_sync)
  );

  // Idle-high line so a released controller reads as "nothing pressed".
  sync_2ff #(.RESET_VAL(1'b1)) u_data_sync (
    .clk   (clk),
    .reset (rst_sync),
    .d     (pad_data),
    .q     (synced_data)
  );

  assign pad_latch = (state == ST_LATCH);
  assign pad_clk   = (state == ST_CLK_HI);

  always_comb begin
    frame_start = (state == ST_IDLE) && en && (poll_cnt == '0);
    half_done   = (phase_cnt == HALF_LAST);
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      poll_cnt  <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      buttons   <= 8'h00;
      presses   <= 8'h00;
      valid     <= 1'b0;
    end else begin
      presses <= 8'h00;
      valid   <= 1'b0;

      // Poll counter leaves zero only when a frame starts, then free-runs to wrap.
      if (frame_start || (poll_cnt != '0))
        poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          phase_cnt <= '0;
          if (frame_start) state <= ST_LATCH;
        end
        ST_LATCH: begin
          if (phase_cnt == LATCH_LAST) begin
            phase_cnt <= '0;
            state     <= ST_BIT0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_BIT0: begin
          if (half_done) begin
            shreg[7]  <= ~synced_data;
            bit_idx   <= 3'd1;
            phase_cnt <= '0;
            state     <= ST_CLK_HI;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_CLK_HI: begin
          if (half_done) begin
            phase_cnt <= '0;
            state     <= ST_CLK_LO;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_CLK_LO: begin
          if (half_done) begin
            shreg[3'd7 - bit_idx] <= ~synced_data;
            phase_cnt             <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              state   <= ST_CLK_HI;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          buttons <= shreg;
          presses <= shreg & ~buttons;
          valid   <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
